l2_fc_sequencer: RTL and testbench
==================================

L2_FC_SEQUENCER -- requirements
Module: l2_fc_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 10, number of output neurons sequenced (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles waited in WAIT_RES for cal_valid.
REQ-003 SHALL have one clock and a synchronous, active-high reset, as listed in REQ-004/REQ-005.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to classify the current layer-1 activations.
REQ-007 L1_valid  out  1  one-cycle pulse telling the FC layer to latch its 16 activations.
REQ-008 wrom_en  out  1  weight ROM read enable; ROM rdata is valid the cycle after wrom_en.
REQ-009 wrom_addr  out  4  weight ROM row address, equal to the neuron index.
REQ-010 wrom_rdata  in  192  weight ROM read data; [127:0] holds 16 x 8-bit weights.
REQ-011 weight_data  out  192  registered weight row presented to the FC layer.
REQ-012 data_ready  out  1  one-cycle pulse to start the FC multiply stage.
REQ-013 L2_bias_sel  out  4  bias select = current neuron index.
REQ-014 L2_result  in  8  FC output, signed two's complement.
REQ-015 cal_valid  in  1  one-cycle pulse qualifying L2_result.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of classification.
REQ-018 err  out  1  high when the last run ended on timeout; held until next start.
REQ-019 class_id  out  4  index of the winning neuron; held until next start.
REQ-020 class_score  out  8  signed result of the winning neuron; held until next start.

Function
REQ-021 SHALL implement the FSM IDLE -> LATCH -> FETCH -> LOAD -> ISSUE -> WAIT_RES -> (FETCH | DONE) -> IDLE, with neuron counter n starting at 0.
REQ-022 IDLE: start=1 -> LATCH; clear n, err, class_id, class_score, and the max-valid flag.
REQ-023 LATCH: L1_valid=1 for exactly this one cycle -> FETCH.
REQ-024 FETCH: wrom_en=1, wrom_addr=n for one cycle -> LOAD.
REQ-025 LOAD: weight_data <= wrom_rdata at the end of the cycle -> ISSUE.
REQ-026 ISSUE: data_ready=1 for exactly one cycle with weight_data stable -> WAIT_RES.
REQ-027 L2_bias_sel SHALL equal n from FETCH through WAIT_RES and SHALL not change before cal_valid is accepted.
REQ-028 weight_data SHALL hold its value from LOAD until the next LOAD.
REQ-029 WAIT_RES, cal_valid=1: capture L2_result; go to FETCH with n+1 if n<NUM_OUT-1, else to DONE.
REQ-030 The FC layer returns cal_valid exactly 3 cycles after the ISSUE cycle; the nominal per-neuron cost is 6 cycles.
REQ-031 Argmax update: the first captured result loads unconditionally; a later result replaces class_id/class_score only if it is strictly greater as a signed 8-bit value.
REQ-032 Argmax ties SHALL keep the lower index.
REQ-033 WAIT_RES timeout: if cal_valid has not arrived when the wait counter reaches TIMEOUT, set err=1 and go to DONE; the partial argmax is kept.
REQ-034 DONE: done=1 for one cycle -> IDLE.
REQ-035 start outside IDLE SHALL be ignored.
REQ-036 cal_valid outside WAIT_RES SHALL be ignored.
REQ-037 cal_valid and timeout expiry in the same cycle: cal_valid wins.
REQ-038 L1_valid, wrom_en, data_ready and done SHALL never be high in the same cycle.
REQ-039 A nominal run with NUM_OUT=10 SHALL take 63 cycles from start to done: LATCH 1 + 10x6 + 1 + DONE.

Reset
REQ-040 rst=1 SHALL force IDLE on the next edge, including mid-run.
REQ-041 On reset, all outputs SHALL go to 0: weight_data, L2_bias_sel, class_id, class_score, err, busy, done, L1_valid, wrom_en, data_ready.
REQ-042 On reset, n and the wait counter SHALL clear.
REQ-043 No pulse output SHALL assert in the cycle after reset deasserts unless start=1 was sampled in that cycle.

Verification
REQ-044 Nominal run: the bench model returns cal_valid 3 cycles after data_ready with results {5,-3,7,2,7,0,-128,1,6,4} -> class_id=2, class_score=7, err=0, done at cycle 63 after start.
REQ-045 All-negative results {-1,-2,...,-10} -> class_id=0, class_score=-1 (0xFF), confirming the signed compare.
REQ-046 Timeout: the model omits cal_valid for neuron 4 -> err=1, done after 16 wait cycles, class_id chosen from neurons 0..3 only.
REQ-047 Protocol check: wrom_addr and L2_bias_sel step 0..9; exactly one data_ready per neuron, issued after LOAD; a start pulse while busy changes nothing.
REQ-048 Reset mid-run: rst=1 during WAIT_RES of neuron 5 -> IDLE next cycle, all outputs 0; a following start begins again at neuron 0.

Source files
------------

// File: rtl/l2_fc_sequencer.sv
// Sequences the second (fully connected) layer one output neuron at a time.
// It fetches each weight row, launches the FC multiply, and keeps a running signed argmax.
module l2_fc_sequencer #(
  parameter int NUM_OUT = 10,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         L1_valid,
  output logic         wrom_en,
  output logic [3:0]   wrom_addr,
  input  logic [191:0] wrom_rdata,
  output logic [191:0] weight_data,
  output logic         data_ready,
  output logic [3:0]   L2_bias_sel,
  input  logic [7:0]   L2_result,
  input  logic         cal_valid,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   class_id,
  output logic [7:0]   class_score,
  output logic [2:0]   state_dbg
);

  // Handshake: every strobe here is a one-cycle pulse with no back-pressure.
  // start is honoured only in IDLE and cal_valid only in WAIT_RES. The FC layer
  // answers data_ready with a cal_valid pulse, which carries L2_result.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    FETCH    = 3'd2,
    LOAD     = 3'd3,
    ISSUE    = 3'd4,
    WAIT_RES = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0]    LAST_N = 4'(NUM_OUT - 1);
  localparam logic [WW-1:0] LAST_W = WW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    n;
  logic [WW-1:0] wait_cnt;
  logic          max_valid;
  logic          accept;
  logic          expire;

  assign accept = (state == WAIT_RES) && cal_valid;
  // A result that arrives on the final wait cycle still counts.
  assign expire = (state == WAIT_RES) && !cal_valid && (wait_cnt == LAST_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LATCH;
      LATCH:    state_nxt = FETCH;
      FETCH:    state_nxt = LOAD;
      LOAD:     state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_RES;
      WAIT_RES: begin
        if (accept) begin
          state_nxt = (n == LAST_N) ? DONE : FETCH;
        end else if (expire) begin
          state_nxt = DONE;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    L1_valid   = 1'b0;
    wrom_en    = 1'b0;
    wrom_addr  = 4'd0;
    data_ready = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE:  busy = 1'b0;
      LATCH: L1_valid = 1'b1;
      FETCH: begin
        wrom_en   = 1'b1;
        wrom_addr = n;
      end
      ISSUE: data_ready = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign L2_bias_sel = n;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      n           <= 4'd0;
      wait_cnt    <= '0;
      weight_data <= '0;
      err         <= 1'b0;
      class_id    <= 4'd0;
      class_score <= 8'd0;
      max_valid   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        n           <= 4'd0;
        err         <= 1'b0;
        class_id    <= 4'd0;
        class_score <= 8'd0;
        max_valid   <= 1'b0;
      end
      if (state == LOAD) begin
        weight_data <= wrom_rdata;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end
      if (accept) begin
        // Strictly greater keeps the lower index when scores tie.
        if (!max_valid || ($signed(L2_result) > $signed(class_score))) begin
          class_id    <= n;
          class_score <= L2_result;
        end
        max_valid <= 1'b1;
        if (n != LAST_N) begin
          n <= n + 4'd1;
        end
      end else if (expire) begin
        err <= 1'b1;
      end else if (state == WAIT_RES) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_fc_sequencer.sv
// Directed bench for l2_fc_sequencer: nominal, signed, timeout and mid-run reset runs.
// It models the weight ROM and an FC layer that answers 3 cycles after data_ready.
module tb_l2_fc_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         L1_valid;
  logic         wrom_en;
  logic [3:0]   wrom_addr;
  logic [191:0] wrom_rdata;
  logic [191:0] weight_data;
  logic         data_ready;
  logic [3:0]   L2_bias_sel;
  logic [7:0]   L2_result;
  logic         cal_valid;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   class_id;
  logic [7:0]   class_score;
  logic [2:0]   state_dbg;

  int vectors;
  int miscompares;

  int res [10];
  int omit_idx;
  logic spurious;

  int   cd;
  int   cur;
  int   fc_idx;
  logic rom_pending;
  logic [3:0] rom_addr_q;

  l2_fc_sequencer #(.NUM_OUT(10), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .L1_valid(L1_valid),
    .wrom_en(wrom_en),
    .wrom_addr(wrom_addr),
    .wrom_rdata(wrom_rdata),
    .weight_data(weight_data),
    .data_ready(data_ready),
    .L2_bias_sel(L2_bias_sel),
    .L2_result(L2_result),
    .cal_valid(cal_valid),
    .busy(busy),
    .done(done),
    .err(err),
    .class_id(class_id),
    .class_score(class_score),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] rom_row(input logic [3:0] a);
    return {48{a}} ^ {6{32'hA5C3_0F96}};
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".l1_valid"}, L1_valid, 0);
    chk({tag, ".wrom_en"}, wrom_en, 0);
    chk({tag, ".data_ready"}, data_ready, 0);
    chk({tag, ".weight_data"}, weight_data, 0);
    chk({tag, ".bias_sel"}, L2_bias_sel, 0);
    chk({tag, ".class_id"}, class_id, 0);
    chk({tag, ".class_score"}, class_score, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".state"}, state_dbg, 0);
  endtask

  // ROM and FC layer model; the start cycle of a run is counted as cycle 1.
  initial begin
    cd = -1;
    cur = 0;
    fc_idx = 0;
    rom_pending = 1'b0;
    rom_addr_q = 4'd0;
    cal_valid = 1'b0;
    L2_result = 8'd0;
    wrom_rdata = '0;
    forever begin
      @(negedge clk);
      cal_valid = 1'b0;
      L2_result = 8'($urandom_range(0, 255));
      wrom_rdata = rom_pending ? rom_row(rom_addr_q) : {6{$urandom}};
      rom_pending = wrom_en;
      rom_addr_q = wrom_addr;
      if (L1_valid) begin
        fc_idx = 0;
        cd = -1;
      end
      if (spurious && wrom_en) begin
        cal_valid = 1'b1;
        L2_result = 8'd127;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0 && cur != omit_idx) begin
          cal_valid = 1'b1;
          L2_result = 8'(res[cur]);
        end
      end
      if (data_ready) begin
        cd = 3;
        cur = fc_idx;
        fc_idx++;
      end
    end
  end

  task automatic do_run(input string name, input int poke_cyc, input int rst_cyc,
                        input int exp_done, input int exp_fetch, input logic [3:0] exp_id,
                        input logic [7:0] exp_score, input logic exp_err);
    int cyc;
    int done_cyc;
    int fetch_cnt;
    int issue_cnt;
    int fetch_cyc;
    int overlap;
    logic stop;
    cyc = 1;
    done_cyc = 0;
    fetch_cnt = 0;
    issue_cnt = 0;
    fetch_cyc = 0;
    overlap = 0;
    stop = 1'b0;
    start = 1'b1;
    while (!stop && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_cyc);
      if (cyc == 2) begin
        chk({name, ".l1_valid"}, L1_valid, 1);
        chk({name, ".err_cleared"}, err, 0);
        chk({name, ".score_cleared"}, class_score, 0);
      end
      if ($countones({L1_valid, wrom_en, data_ready, done}) > 1) overlap++;
      if (wrom_en) begin
        chk({name, ".wrom_addr"}, wrom_addr, fetch_cnt[3:0]);
        fetch_cnt++;
        fetch_cyc = cyc;
      end
      if (data_ready) begin
        chk({name, ".bias_sel"}, L2_bias_sel, issue_cnt[3:0]);
        chk({name, ".weight_data"}, weight_data, rom_row(issue_cnt[3:0]));
        chk({name, ".issue_gap"}, cyc - fetch_cyc, 2);
        issue_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        stop = 1'b1;
      end
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        chk({name, ".pre_rst_bias"}, L2_bias_sel, 5);
        chk({name, ".pre_rst_busy"}, busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs({name, ".after_rst"});
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    chk({name, ".done_cycle"}, done_cyc, exp_done);
    chk({name, ".fetch_count"}, fetch_cnt, exp_fetch);
    chk({name, ".issue_count"}, issue_cnt, exp_fetch);
    chk({name, ".pulse_overlap"}, overlap, 0);
    chk({name, ".busy_at_done"}, busy, 1);
    chk({name, ".class_id"}, class_id, exp_id);
    chk({name, ".class_score"}, class_score, exp_score);
    chk({name, ".err"}, err, exp_err);
    @(negedge clk);
    chk({name, ".idle_busy"}, busy, 0);
    chk({name, ".idle_done"}, done, 0);
    chk({name, ".held_id"}, class_id, exp_id);
    chk({name, ".held_score"}, class_score, exp_score);
    chk({name, ".held_err"}, err, exp_err);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    omit_idx = -1;
    spurious = 1'b0;
    res = '{5, -3, 7, 2, 7, 0, -128, 1, 6, 4};
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst.pulses", {L1_valid, wrom_en, data_ready, done, busy}, 0);
    end

    // Ties at index 2 and 4 must keep 2; the extra start at cycle 20 must be ignored.
    do_run("nominal", 20, 0, 63, 10, 4'd2, 8'd7, 1'b0);

    // All negative: the signed max is -1 at index 0; stray cal_valid in FETCH is ignored.
    res = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    spurious = 1'b1;
    do_run("negative", 0, 0, 63, 10, 4'd0, 8'hFF, 1'b0);
    spurious = 1'b0;

    // Neuron 4 never answers: done after 16 wait cycles, argmax from neurons 0..3.
    res = '{-5, 3, -2, 9, 50, 120, 1, 1, 1, 1};
    omit_idx = 4;
    do_run("timeout", 0, 0, 46, 5, 4'd3, 8'd9, 1'b1);
    omit_idx = -1;

    // Reset while neuron 5 waits for its result, then a clean rerun from neuron 0.
    res = '{5, -3, 7, 2, 7, 0, -128, 1, 6, 4};
    do_run("midreset", 0, 36, 0, 0, 4'd0, 8'd0, 1'b0);
    do_run("rerun", 0, 0, 63, 10, 4'd2, 8'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
